multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I core. Sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction.
- Sits beside the multi-cycle datapath. It drives every mux select and write enable, evaluates branch conditions, and waits on memory through a ready handshake.
- The ALU decoder is a separate block; it takes ALUOp, funct3 and funct7b5 from this block's outputs.

Parameters:
- None. The state encoding is internal and free; the outputs below are fixed.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
op  input  7  instruction opcode, from the IR
funct3  input  3  instruction funct3, from the IR
Zero  input  1  ALU result == 0
ALUR31  input  1  ALU result bit 31 (less-than flag from the compare)
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  PC <= Result
AdrSrc  output  1  memory address: 0 = PC, 1 = Result
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR <= ReadData and OldPC <= PC
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 register
ALUSrcB  output  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
ALUOp  output  2  00 = add, 01 = branch compare, 10 = decode by funct
ImmSrc  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal_instr  output  1  sticky flag: trap state entered

Behaviour:
- One clock. Reset is synchronous and active-high. On any clk edge with reset=1, the state becomes FETCH and illegal_instr clears. This applies mid-instruction and mid-wait.
- While reset=1: PCWrite, MemWrite, IRWrite, RegWrite and instr_done are forced 0.
- Outputs are Moore decodes of the state. Exceptions: mem_ready gates the FETCH enables, and the branch decision gates PCWrite in BRANCH.
- Any output not listed for a state is 0: selects 00, ImmSrc 000.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite = mem_ready. Hold while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, giving ALUOut = OldPC+imm. ImmSrc=011 if op=JAL, else 010. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH if funct3 is not 010/011, else TRAP
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. ImmSrc=000 for a load, 001 for a store. Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high until the cycle mem_ready=1 (inclusive); in that cycle instr_done=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=10. Next: ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100, ALUOp=00. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH.
- LUI: ResultSrc=11, ImmSrc=100, RegWrite=1, instr_done=1. Next: FETCH.
- JAL: ResultSrc=00, PCWrite=1 (PC <= target); ALUSrcA=01, ALUSrcB=10, ALUOp=00 (computes OldPC+4). Next: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00, ResultSrc=10, PCWrite=1. Next: JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1, instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done=1. PCWrite = taken. Next: FETCH.
  - taken = Zero for BEQ; !Zero for BNE; ALUR31 for BLT and BLTU; !ALUR31 for BGE and BGEU.
- TRAP: illegal_instr=1 and all enables 0. Stays until reset.
- Cycle counts with mem_ready=1 throughout: R/I/AUIPC = 4, LUI = 3, load = 5, store = 4, branch = 3, JAL = 4, JALR = 4. Each cycle of mem_ready=0 adds exactly one cycle to FETCH, MEMREAD or MEMWRITE.

Test Plan:
- add (op 0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4; instr_done pulses in cycle 4.
- lw with mem_ready held 0 for 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite assert only on the ready cycle; 10 cycles total; AdrSrc=1 for all of MEMREAD.
- sw with mem_ready=0 for 1 cycle -> MemWrite high for exactly 2 cycles with AdrSrc=1; RegWrite never asserts.
- beq with Zero=1, then Zero=0; bltu with ALUR31=1 -> PCWrite=1, 0, 1 in the BRANCH cycle respectively.
- jalr -> PCWrite in cycle 3 with ResultSrc=10; RegWrite in cycle 4 with ALUSrcA=01 and ALUSrcB=10.
- op=1111111 -> TRAP; illegal_instr stays 1 over 20 cycles. Reset pulse -> FETCH next cycle and illegal_instr=0. Reset asserted during MEMREAD -> FETCH, no RegWrite.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences the shared ALU, the unified
// memory port and the register file, one state per datapath cycle.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_AUIPC, S_ALUWB, S_LUI, S_JAL, S_JALR,
        S_JALRWB, S_BRANCH, S_TRAP
    } state_t;

    state_t state_q, state_d;
    logic   taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // funct3[2] picks the less-than flag over Zero; funct3[0] inverts the sense.
    always_comb begin
        taken = funct3[2] ? (ALUR31 ^ funct3[0]) : (Zero ^ funct3[0]);
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        ImmSrc        = 3'b000;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            // op[5] is the only bit separating store from load.
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 3'b001 : 3'b000;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                ResultSrc  = 2'b11;
                ImmSrc     = 3'b100;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            // Target was computed into ALUOut during DECODE; the link value goes through ALUWB.
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_JALRWB;
            end
            S_JALRWB: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = taken;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
